// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   - Default address/data widths.
//   - Arbiter FSM state encodings.
package mem_port_arbiter_pkg;

   localparam int unsigned ARB_ADDR_W = 32;
   localparam int unsigned ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_D = 2'd1,
      ARB_BUSY_I = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_req_tracker.sv
// Per-requester completion tracker: done flag, drop flag and held result.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      clear done (pipeline advances, or redirect)
//   flush      discard the result of the transaction for this requester
//   busy       a transaction for this requester is in flight
//   complete   the in-flight transaction finishes on this edge
//   capture    store rdata into result on completion (loads / fetches)
//   rdata      memory read data
//   done       result available for the current pipeline step
//   result     last captured read data, held until the next capture
module mem_port_arbiter_req_tracker
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = ARB_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              flush,
   input  logic              busy,
   input  logic              complete,
   input  logic              capture,
   input  logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   logic              done_q, done_d;
   logic              drop_q, drop_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              discard;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q   <= done_d;
         drop_q   <= drop_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      // A redirect landing on the completion edge discards the result too.
      discard  = drop_q | flush;
      done_d   = done_q;
      drop_d   = drop_q;
      result_d = result_q;
      if (clear) begin
         done_d = 1'b0;
      end
      if (complete) begin
         drop_d = 1'b0;
         if (!discard) begin
            done_d = 1'b1;
            if (capture) begin
               result_d = rdata;
            end
         end
      end else if (flush && busy) begin
         // Memory side still has to finish; remember to throw the data away.
         drop_d = 1'b1;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between IF (fetch) and MEM (load/store).
// Data requests win over fetches; one transaction at a time, held until mem_ready.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   if_req/if_addr/if_flush           fetch request, PC, redirect
//   if_done/if_rdata                  fetch complete for this step, fetched word
//   d_req/d_we/d_addr/d_wdata/d_wstrb data request (load/store)
//   d_done/d_rdata                    data access complete for this step, load data
//   stall                             freeze pipeline registers and PC
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  memory request (registered)
//   mem_ready/mem_rdata               memory handshake and read data
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ARB_ADDR_W,
   parameter int unsigned DATA_W = ARB_DATA_W,
   parameter int unsigned STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

   logic pend_d, pend_i;
   logic busy_d, busy_i;
   logic d_complete, i_complete;

   // State register, including the held memory request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
      end
   end

   // Next state: grant only from IDLE; BUSY holds mem_* until mem_ready.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pend_d) begin
               state_d     = ARB_BUSY_D;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_wstrb_d = d_wstrb;
            end else if (pend_i) begin
               state_d     = ARB_BUSY_I;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wstrb_d = '0;
            end
         end
         ARB_BUSY_D, ARB_BUSY_I: begin
            if (mem_ready) begin
               state_d   = ARB_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = ARB_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // Outputs and request decode.
   always_comb begin
      pend_d     = d_req & ~d_done;
      pend_i     = if_req & ~if_done & ~if_flush;
      stall      = (if_req & ~if_done) | (d_req & ~d_done);
      busy_d     = (state_q == ARB_BUSY_D);
      busy_i     = (state_q == ARB_BUSY_I);
      d_complete = busy_d & mem_ready;
      i_complete = busy_i & mem_ready;
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

   // Done flags clear on the edge where the pipeline advances (stall low).
   mem_port_arbiter_req_tracker #(
      .DATA_W (DATA_W)
   ) u_d_track (
      .clk      (clk),
      .rst      (rst),
      .clear    (~stall),
      .flush    (1'b0),
      .busy     (busy_d),
      .complete (d_complete),
      .capture  (~mem_we_q),
      .rdata    (mem_rdata),
      .done     (d_done),
      .result   (d_rdata)
   );

   mem_port_arbiter_req_tracker #(
      .DATA_W (DATA_W)
   ) u_if_track (
      .clk      (clk),
      .rst      (rst),
      .clear    (~stall | if_flush),
      .flush    (if_flush),
      .busy     (busy_i),
      .complete (i_complete),
      .capture  (1'b1),
      .rdata    (mem_rdata),
      .done     (if_done),
      .result   (if_rdata)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_flush, if_done;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_done;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [SW-1:0] d_wstrb;
   logic          stall;
   logic          mem_req, mem_we, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [SW-1:0] mem_wstrb;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .STRB_W (SW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_done   (if_done),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wstrb   (d_wstrb),
      .d_done    (d_done),
      .d_rdata   (d_rdata),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory model: fixed contents, programmable wait states.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      case (a)
         32'h40:  return 32'h2002_0005;
         32'h100: return 32'hDEAD_BEEF;
         32'h80:  return 32'hFFFF_FFFF;
         default: return {16'hC0DE, a[15:0]};
      endcase
   endfunction

   int unsigned   waits = 0;
   bit            ready_tied = 1'b0;
   int unsigned   wcnt = 0;
   logic [31:0]   txn_log[$];
   logic [31:0]   last_st_wdata = '0;
   logic [3:0]    last_st_wstrb = '0;

   assign mem_ready = ready_tied | (mem_req && (wcnt == waits));
   assign mem_rdata = mem_fn(mem_addr);

   always @(posedge clk) begin
      if (!mem_req || mem_ready) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (mem_req && mem_ready) begin
         txn_log.push_back(mem_addr);
         if (mem_we) begin
            last_st_wdata <= mem_wdata;
            last_st_wstrb <= mem_wstrb;
         end
      end
   end

   // Scoreboard: expected held results, popped when a done flag rises.
   logic [31:0] if_q[$];
   logic [31:0] d_q[$];
   logic        if_done_p = 1'b0, d_done_p = 1'b0;
   logic [31:0] mon_exp_if, mon_exp_d;

   always @(negedge clk) begin
      if (if_done && !if_done_p) begin
         if (if_q.size() == 0) check("if_sb_nonempty", if_q.size(), 1);
         else begin
            mon_exp_if = if_q.pop_front();
            check("if_sb_rdata", if_rdata, mon_exp_if);
         end
      end
      if (d_done && !d_done_p) begin
         if (d_q.size() == 0) check("d_sb_nonempty", d_q.size(), 1);
         else begin
            mon_exp_d = d_q.pop_front();
            check("d_sb_rdata", d_rdata, mon_exp_d);
         end
      end
      if_done_p = if_done;
      d_done_p  = d_done;
   end

   task automatic wait_stall_low(output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (!stall) break;
         n++;
         if (n > 64) begin
            tests++;
            failed++;
            $display("FAIL stall_timeout: stall still high after %0d cycles, expected low", n);
            break;
         end
      end
   endtask

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_wstrb;
      int          waits;
      int          exp_stall;
      int          exp_txn;
      logic [31:0] exp_if_rdata;
      logic [31:0] exp_d_rdata;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      int base;
      int delta;
      @(posedge clk); #1;
      waits   = v.waits;
      base    = txn_log.size();
      if_req  = v.if_req;
      if_addr = v.if_addr;
      d_req   = v.d_req;
      d_we    = v.d_we;
      d_addr  = v.d_addr;
      d_wdata = v.d_wdata;
      d_wstrb = v.d_wstrb;
      if (v.if_req) if_q.push_back(v.exp_if_rdata);
      if (v.d_req) d_q.push_back(v.exp_d_rdata);
      wait_stall_low(n);
      delta = txn_log.size() - base;
      check($sformatf("v%0d_stall_cycles", idx), n, v.exp_stall);
      check($sformatf("v%0d_if_done", idx), if_done, v.if_req);
      check($sformatf("v%0d_d_done", idx), d_done, v.d_req);
      check($sformatf("v%0d_if_rdata", idx), if_rdata, v.exp_if_rdata);
      check($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_d_rdata);
      check($sformatf("v%0d_txn_count", idx), delta, v.exp_txn);
      if (v.d_req && delta >= 1)
         check($sformatf("v%0d_first_txn_addr", idx), txn_log[base], v.d_addr);
      if (v.d_req && v.if_req && delta >= 2)
         check($sformatf("v%0d_second_txn_addr", idx), txn_log[base+1], v.if_addr);
      if (v.d_req && v.d_we) begin
         check($sformatf("v%0d_st_wdata", idx), last_st_wdata, v.d_wdata);
         check($sformatf("v%0d_st_wstrb", idx), last_st_wstrb, v.d_wstrb);
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_if_done_clr", idx), if_done, 0);
      check($sformatf("v%0d_d_done_clr", idx), d_done, 0);
   endtask

   task automatic flush_test(input int fat, input logic [31:0] new_addr,
                             input logic [31:0] old_exp);
      int n;
      waits = 1;
      @(posedge clk); #1;
      if_req  = 1'b1;
      if_addr = 32'h80;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         if (c == fat) begin
            if_flush = 1'b1;
            if_addr  = new_addr;
         end else if (c == fat + 1) begin
            if_flush = 1'b0;
            if_q.push_back(mem_fn(new_addr));
         end
         @(negedge clk);
         if (c == 2) begin
            check($sformatf("fl%0d_c2_mem_req", fat), mem_req, 1);
            check($sformatf("fl%0d_c2_mem_addr", fat), mem_addr, 32'h80);
         end
         if (c == 3) begin
            check($sformatf("fl%0d_c3_if_done", fat), if_done, 0);
            check($sformatf("fl%0d_c3_if_rdata_held", fat), if_rdata, old_exp);
         end
         if (c == 4) begin
            check($sformatf("fl%0d_c4_mem_req", fat), mem_req, 1);
            check($sformatf("fl%0d_c4_mem_addr", fat), mem_addr, new_addr);
         end
      end
      wait_stall_low(n);
      check($sformatf("fl%0d_new_if_done", fat), if_done, 1);
      check($sformatf("fl%0d_new_if_rdata", fat), if_rdata, mem_fn(new_addr));
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   initial begin
      int n;
      int base;

      vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 0, 2, 1,
                  32'h2002_0005, 32'h0000_0000};
      vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,         4'h0, 0, 2, 1,
                  32'h2002_0005, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,         4'h0, 0, 4, 2,
                  32'hC0DE_0044, 32'hDEAD_BEEF};
      vecs[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10,  32'h1234_5678, 4'h3, 2, 4, 1,
                  32'hC0DE_0044, 32'hDEAD_BEEF};
      vecs[4] = '{1'b1, 32'h48, 1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 1, 3, 1,
                  32'hC0DE_0048, 32'hDEAD_BEEF};
      vecs[5] = '{1'b1, 32'h4C, 1'b1, 1'b1, 32'h20,  32'hAABB_CCDD, 4'hC, 1, 6, 2,
                  32'hC0DE_004C, 32'hDEAD_BEEF};
      vecs[6] = '{1'b1, 32'h50, 1'b1, 1'b0, 32'h200, 32'h0,         4'h0, 1, 6, 2,
                  32'hC0DE_0050, 32'hC0DE_0200};
      vecs[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,         4'h0, 0, 0, 0,
                  32'hC0DE_0050, 32'hC0DE_0200};

      rst      = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      if_flush = 1'b0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      d_wstrb  = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wstrb", mem_wstrb, 0);
      check("rst_if_done", if_done, 0);
      check("rst_d_done", d_done, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_stall", stall, 0);
      rst = 1'b0;

      // Lone fetch, zero-wait memory, cycle by cycle; mem_ready tied high.
      ready_tied = 1'b1;
      @(posedge clk); #1;
      base    = txn_log.size();
      if_req  = 1'b1;
      if_addr = 32'h40;
      if_q.push_back(32'h2002_0005);
      @(negedge clk);
      check("t1_c0_stall", stall, 1);
      check("t1_c0_mem_req", mem_req, 0);
      @(negedge clk);
      check("t1_c1_mem_req", mem_req, 1);
      check("t1_c1_mem_addr", mem_addr, 32'h40);
      check("t1_c1_mem_we", mem_we, 0);
      check("t1_c1_stall", stall, 1);
      @(negedge clk);
      check("t1_c2_if_done", if_done, 1);
      check("t1_c2_if_rdata", if_rdata, 32'h2002_0005);
      check("t1_c2_stall", stall, 0);
      check("t1_c2_mem_req", mem_req, 0);
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      check("t1_c3_if_done", if_done, 0);
      check("t1_txn_count", txn_log.size() - base, 1);
      ready_tied = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Store with two wait states; requester inputs change mid-transaction.
      waits = 2;
      @(posedge clk); #1;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h10;
      d_wdata = 32'h1234_5678;
      d_wstrb = 4'h3;
      d_q.push_back(32'hC0DE_0200);
      @(negedge clk);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            d_wdata = 32'hFFFF_0000;
            d_addr  = 32'h999;
            d_wstrb = 4'hF;
            d_we    = 1'b0;
         end
         @(negedge clk);
         check($sformatf("st_c%0d_mem_req", c), mem_req, 1);
         check($sformatf("st_c%0d_mem_we", c), mem_we, 1);
         check($sformatf("st_c%0d_mem_addr", c), mem_addr, 32'h10);
         check($sformatf("st_c%0d_mem_wdata", c), mem_wdata, 32'h1234_5678);
         check($sformatf("st_c%0d_mem_wstrb", c), mem_wstrb, 4'h3);
      end
      @(negedge clk);
      check("st_d_done", d_done, 1);
      check("st_d_rdata_held", d_rdata, 32'hC0DE_0200);
      check("st_logged_wdata", last_st_wdata, 32'h1234_5678);
      @(posedge clk); #1;
      d_req = 1'b0;
      d_we  = 1'b0;

      // Redirect while a fetch is in flight, and on its completion cycle.
      flush_test(1, 32'h200, 32'hC0DE_0050);
      flush_test(2, 32'h204, 32'hC0DE_0200);

      // Reset in the middle of a data transaction.
      waits = 3;
      @(posedge clk); #1;
      base   = txn_log.size();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h100;
      @(posedge clk); #1;
      check("rs_mem_req_before", mem_req, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rs_mem_req", mem_req, 0);
      check("rs_d_done", d_done, 0);
      check("rs_if_done", if_done, 0);
      check("rs_d_rdata", d_rdata, 0);
      check("rs_if_rdata", if_rdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      d_q.push_back(32'hDEAD_BEEF);
      wait_stall_low(n);
      check("rs_stall_cycles", n, 5);
      check("rs_d_done_after", d_done, 1);
      check("rs_d_rdata_after", d_rdata, 32'hDEAD_BEEF);
      check("rs_txn_count", txn_log.size() - base, 1);
      @(posedge clk); #1;
      d_req = 1'b0;

      // Three back-to-back fetches; mem_ready high even while idle.
      ready_tied = 1'b1;
      waits      = 0;
      @(posedge clk); #1;
      base    = txn_log.size();
      if_req  = 1'b1;
      if_addr = 32'h40;
      if_q.push_back(mem_fn(32'h40));
      for (int k = 0; k < 3; k++) begin
         wait_stall_low(n);
         check($sformatf("bb%0d_stall_cycles", k), n, 2);
         check($sformatf("bb%0d_if_done", k), if_done, 1);
         @(posedge clk); #1;
         if (k < 2) begin
            if_addr = 32'h44 + 32'(4 * k);
            if_q.push_back(mem_fn(if_addr));
         end else begin
            if_req = 1'b0;
         end
      end
      @(negedge clk);
      check("bb_txn_count", txn_log.size() - base, 3);
      check("bb_if_done_clr", if_done, 0);
      @(negedge clk);
      check("bb_idle_mem_req", mem_req, 0);
      check("bb_idle_if_done", if_done, 0);
      ready_tied = 1'b0;

      check("if_sb_drained", if_q.size(), 0);
      check("d_sb_drained", d_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store, driven by MemRead/MemWrite decode).
- Fixed priority: data beats instruction, because MEM holds the older instruction.
- Issues one memory transaction at a time and holds each request stable until the memory acknowledges it.
- Drives a pipeline-wide stall until every pending request of the current pipeline step has completed.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STRB_W, DATA_W/8, byte-strobe width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  IF fetch request; level, held while stalled
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  branch/jump redirect; discard any fetch result for the current PC
- if_done  out  1  fetch result available for the current pipeline step
- if_rdata  out  DATA_W  fetched instruction, held until the next fetch completes
- d_req  in  1  data request (MemRead | MemWrite); level
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  STRB_W  store byte enables
- d_done  out  1  data access complete for the current pipeline step
- d_rdata  out  DATA_W  load data, held until the next data read completes
- stall  out  1  freeze all pipeline registers and the PC
- mem_req  out  1  memory transaction valid
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  STRB_W  memory byte enables
- mem_ready  in  1  transaction accepted/complete this cycle; read data valid on mem_rdata in the same cycle
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE.
  - mem_req, mem_we, if_done, d_done, drop_if = 0.
  - mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata = 0.
  - A transaction in flight is abandoned; the memory must tolerate mem_req falling without mem_ready.
- Combinational outputs:
  - stall = (if_req & ~if_done) | (d_req & ~d_done).
  - pend_d = d_req & ~d_done.
  - pend_i = if_req & ~if_done & ~if_flush.
- FSM states: IDLE, BUSY_D, BUSY_I.
  - IDLE, pend_d: latch d_we/d_addr/d_wdata/d_wstrb into mem_*, mem_req <= 1, go to BUSY_D.
  - IDLE, else pend_i: latch if_addr, mem_we <= 0, mem_wstrb <= 0, mem_req <= 1, go to BUSY_I.
  - IDLE, neither: remain in IDLE.
  - BUSY_D, mem_ready: d_rdata <= mem_rdata (loads only; stores leave d_rdata unchanged), d_done <= 1, mem_req <= 0, go to IDLE.
  - BUSY_I, mem_ready: if drop_if, discard the data and leave if_done = 0; else if_rdata <= mem_rdata and if_done <= 1. Then drop_if <= 0, mem_req <= 0, go to IDLE.
  - While BUSY, mem_* are held constant regardless of any change on the requester inputs.
- Done flags:
  - At any edge where stall == 0, clear both if_done and d_done; the pipeline advances on that edge.
  - No grant is made on that edge, because no request is pending.
  - Net effect: at most one bubble cycle between pipeline steps when the memory is used.
- Flush:
  - if_flush clears if_done at the next edge.
  - If the state is BUSY_I, also set drop_if; the fetch completes on the memory side and its result is discarded.
  - if_flush in the same cycle as an IF completion: the result is discarded.
  - if_flush has no effect on the data side.
- Latency:
  - Request in IDLE → mem_req on the next cycle.
  - With zero-wait memory (mem_ready in the first mem_req cycle), done asserts 2 cycles after the request.
  - Each wait cycle of mem_ready adds 1 cycle.
- Simultaneous requests: data first, then fetch. Worst case with zero-wait memory is 4 stall cycles.
- mem_ready while IDLE: ignored.

Decomposition:
- Shared defines header, next to the existing opcode/funct defines: FSM state encodings (ARB_IDLE, ARB_BUSY_D, ARB_BUSY_I) and the default widths.
- One natural sub-module, req_tracker: the per-requester done/drop flag and result register, instanced twice (IF and D). Arbitration and the FSM stay in the top.

Test Plan:
1. Lone fetch, zero-wait memory:
   - Stimulus: if_req = 1, if_addr = 0x0000_0040, mem_ready tied 1, mem_rdata = 0x2002_0005.
   - Required: mem_req high in cycle 1; if_done and if_rdata = 0x2002_0005 in cycle 2; stall high in cycles 0–1, low in cycle 2; flags cleared in cycle 3.
2. Simultaneous load and fetch:
   - Stimulus: d_req = 1, d_we = 0, d_addr = 0x100, if_addr = 0x44; memory returns 0xDEAD_BEEF for the data read.
   - Required: data transaction issued first; d_rdata = 0xDEAD_BEEF; IF transaction issued afterwards; stall low only once both done flags are set.
3. Store with 2 wait states:
   - Stimulus: d_we = 1, d_wstrb = 4'b0011, d_wdata = 0x1234_5678; mem_ready asserted on the third mem_req cycle.
   - Required: mem_* stable over all 3 cycles even if d_wdata changes; d_rdata unchanged.
4. Flush during BUSY_I:
   - Stimulus: assert if_flush while a fetch of 0x80 is in flight; the memory returns 0xFFFF_FFFF.
   - Required: if_rdata keeps its old value, if_done stays 0, and a new fetch is issued for the redirected if_addr.
5. Reset mid-transaction:
   - Stimulus: assert rst while in BUSY_D.
   - Required: mem_req, stall contributions and both done flags go to 0 immediately (no clock edge needed); after release, the FSM is in IDLE and re-arbitrates cleanly.
6. Back-to-back steps:
   - Stimulus: 3 consecutive fetches with zero-wait memory.
   - Required: exactly one bubble between steps, no duplicate memory transaction for the same step, and mem_ready while IDLE ignored.
